// File: rtl/weight_fetch_sequencer_if.sv
// Bundle between the weight fetch sequencer, its layer controller, the MAC and one weight BRAM.
// The slave modport is the sequencer's view; the master modport is everything around it.
interface weight_fetch_sequencer_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic          start;
  logic          load_req;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          stall;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic          bram_we;
  logic [DW-1:0] bram_di;
  logic [DW-1:0] bram_do;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_last;
  logic          busy;
  logic          done;

  modport slave (
    input  start, load_req, load_valid, load_data, stall, bram_do,
    output bram_addr, bram_en, bram_we, bram_di, w_data, w_valid, w_last, busy, done
  );

  modport master (
    output start, load_req, load_valid, load_data, stall, bram_do,
    input  bram_addr, bram_en, bram_we, bram_di, w_data, w_valid, w_last, busy, done
  );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// Loads a streamed weight set into a negedge-clocked single-port BRAM, or reads it back in
// address order as a valid/last tagged stream with MAC backpressure.
module weight_fetch_sequencer #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  weight_fetch_sequencer_if.slave io_bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, FLUSH, FIN} state_t;

  state_t        r_state, w_nextState;
  logic [AW-1:0] r_cnt, w_nextCnt;
  logic [AW-1:0] r_addr, w_nextAddr;
  logic          r_en, w_nextEn;
  logic          r_we, w_nextWe;
  logic [DW-1:0] r_di, w_nextDi;
  logic          r_valid;
  logic          r_last;
  logic          r_busy;
  logic          r_done;

  // The end-of-bank test happens before the increment, so DEPTH == 2**AW never wraps.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextAddr  = r_addr;
    w_nextEn    = 1'b0;
    w_nextWe    = 1'b0;
    w_nextDi    = r_di;
    unique case (r_state)
      IDLE: begin
        if (io_bus.load_req) begin
          w_nextState = LOAD;
        end else if (io_bus.start) begin
          w_nextState = FETCH;
        end
      end
      LOAD: begin
        if (io_bus.load_valid) begin
          w_nextEn   = 1'b1;
          w_nextWe   = 1'b1;
          w_nextDi   = io_bus.load_data;
          w_nextAddr = r_cnt;
          if (r_cnt == LAST_ADDR) begin
            w_nextState = FIN;
          end else begin
            w_nextCnt = r_cnt + AW'(1);
          end
        end
      end
      FETCH: begin
        if (!io_bus.stall) begin
          w_nextEn   = 1'b1;
          w_nextAddr = r_cnt;
          if (r_cnt == LAST_ADDR) begin
            w_nextState = FLUSH;
          end else begin
            w_nextCnt = r_cnt + AW'(1);
          end
        end
      end
      FLUSH: begin
        w_nextState = FIN;
      end
      FIN: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Valid/last follow the previous cycle's read request, matching the BRAM's one-cycle latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_en    <= 1'b0;
      r_we    <= 1'b0;
      r_di    <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_addr  <= w_nextAddr;
      r_en    <= w_nextEn;
      r_we    <= w_nextWe;
      r_di    <= w_nextDi;
      r_valid <= r_en & ~r_we;
      r_last  <= r_en & ~r_we & (r_addr == LAST_ADDR);
      r_busy  <= (w_nextState != IDLE);
      r_done  <= (r_state == FIN);
    end
  end

  assign io_bus.bram_addr = r_addr;
  assign io_bus.bram_en   = r_en;
  assign io_bus.bram_we   = r_we;
  assign io_bus.bram_di   = r_di;
  assign io_bus.w_data    = io_bus.bram_do;
  assign io_bus.w_valid   = r_valid;
  assign io_bus.w_last    = r_last;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Scoreboard bench for weight_fetch_sequencer: one 28-deep and one 32-deep instance,
// each wired to a negedge-clocked behavioural BRAM.
module tb_weight_fetch_sequencer;

  localparam int AW     = 5;
  localparam int DW     = 16;
  localparam int DEPTH0 = 28;
  localparam int DEPTH1 = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_fetch_sequencer_if #(.AW(AW), .DW(DW)) if0 ();
  weight_fetch_sequencer_if #(.AW(AW), .DW(DW)) if1 ();

  weight_fetch_sequencer #(.DEPTH(DEPTH0), .AW(AW), .DW(DW)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(if0)
  );

  weight_fetch_sequencer #(.DEPTH(DEPTH1), .AW(AW), .DW(DW)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(if1)
  );

  logic [DW-1:0] mem0 [0:31];
  logic [DW-1:0] mem1 [0:31];
  logic [DW-1:0] doReg0 = '0;
  logic [DW-1:0] doReg1 = '0;
  assign if0.bram_do = doReg0;
  assign if1.bram_do = doReg1;

  always @(negedge clk) begin
    if (if0.bram_en) begin
      if (if0.bram_we) mem0[if0.bram_addr] <= if0.bram_di;
      else             doReg0 <= mem0[if0.bram_addr];
    end
    if (if1.bram_en) begin
      if (if1.bram_we) mem1[if1.bram_addr] <= if1.bram_di;
      else             doReg1 <= mem1[if1.bram_addr];
    end
  end

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [DW-1:0]    fetchQ0 [$];
  logic [DW-1:0]    fetchQ1 [$];
  logic [AW+DW-1:0] writeQ  [$];
  logic [DW-1:0]    exp0, exp1;
  logic [AW+DW-1:0] expW;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic lr, input logic lv,
                               input logic [DW-1:0] ld, input logic sl);
    if0.start      = st;
    if0.load_req   = lr;
    if0.load_valid = lv;
    if0.load_data  = ld;
    if0.stall      = sl;
    tick();
  endtask

  // Fetched words are popped from the scoreboard as they appear; the last pop must carry w_last.
  always @(posedge clk) begin
    #1;
    if (if0.w_valid) begin
      checkOutput("fetch0_expected", 32'(fetchQ0.size() != 0), 1);
      if (fetchQ0.size() != 0) begin
        exp0 = fetchQ0.pop_front();
        checkOutput("fetch0_data", 32'(if0.w_data), 32'(exp0));
        checkOutput("fetch0_last", 32'(if0.w_last), 32'(fetchQ0.size() == 0));
      end
    end
    if (if1.w_valid) begin
      checkOutput("fetch1_expected", 32'(fetchQ1.size() != 0), 1);
      if (fetchQ1.size() != 0) begin
        exp1 = fetchQ1.pop_front();
        checkOutput("fetch1_data", 32'(if1.w_data), 32'(exp1));
        checkOutput("fetch1_last", 32'(if1.w_last), 32'(fetchQ1.size() == 0));
      end
    end
  end

  always @(negedge clk) begin
    if (if0.bram_en && if0.bram_we) begin
      checkOutput("write_expected", 32'(writeQ.size() != 0), 1);
      if (writeQ.size() != 0) begin
        expW = writeQ.pop_front();
        checkOutput("write_addr", 32'(if0.bram_addr), 32'(expW[AW+DW-1:DW]));
        checkOutput("write_data", 32'(if0.bram_di), 32'(expW[DW-1:0]));
      end
    end
  end

  task automatic loadBank(input logic [DW-1:0] base, input int mult, input bit gaps,
                          input int startAt, input bit withStart);
    logic [DW-1:0] d;
    applyStimulus(withStart, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("load_busy_rise", 32'(if0.busy), 1);
    for (int i = 0; i < DEPTH0; i++) begin
      if (gaps && (i == 5 || i == 6)) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      d = DW'(int'(base) + i * mult);
      writeQ.push_back({AW'(i), d});
      applyStimulus(i == startAt, 1'b0, 1'b1, d, 1'b0);
    end
    checkOutput("load_last_addr", 32'(if0.bram_addr), DEPTH0 - 1);
    checkOutput("load_last_we", 32'(if0.bram_we), 1);
    checkOutput("load_done_early", 32'(if0.done), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("load_done", 32'(if0.done), 1);
    checkOutput("load_busy_fall", 32'(if0.busy), 0);
    checkOutput("load_en_fin", 32'(if0.bram_en), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("load_done_pulse", 32'(if0.done), 0);
    checkOutput("load_writes_drained", writeQ.size(), 0);
  endtask

  task automatic runFetch(input int s1, input int l1, input int s2, input int l2,
                          output int firstV, output int nValid, output int lastV,
                          output int doneC, output logic [63:0] seen);
    logic sl;
    firstV = -1; nValid = 0; lastV = -1; doneC = -1; seen = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int c = 1; c <= 60 && doneC < 0; c++) begin
      sl = (c >= s1 && c < s1 + l1) || (c >= s2 && c < s2 + l2);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, sl);
      if (if0.w_valid) begin
        if (firstV < 0) firstV = c;
        nValid++;
        lastV   = c;
        seen[c] = 1'b1;
      end
      if (if0.done) doneC = c;
    end
  endtask

  int          firstV, nValid, lastV, doneC;
  logic [63:0] seen;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    if0.start = 0; if0.load_req = 0; if0.load_valid = 0; if0.load_data = '0; if0.stall = 0;
    if1.start = 0; if1.load_req = 0; if1.load_valid = 0; if1.load_data = '0; if1.stall = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checkOutput("rst_addr", 32'(if0.bram_addr), 0);
    checkOutput("rst_en", 32'(if0.bram_en), 0);
    checkOutput("rst_we", 32'(if0.bram_we), 0);
    checkOutput("rst_di", 32'(if0.bram_di), 0);
    checkOutput("rst_valid", 32'(if0.w_valid), 0);
    checkOutput("rst_last", 32'(if0.w_last), 0);
    checkOutput("rst_busy", 32'(if0.busy), 0);
    checkOutput("rst_done", 32'(if0.done), 0);

    $display("[TB] LOAD with load_valid gaps");
    loadBank(16'h0100, 1, 1'b1, -1, 1'b0);
    for (int i = 0; i < DEPTH0; i++) checkOutput("readback", 32'(mem0[i]), 32'h0100 + i);

    $display("[TB] FETCH without stall");
    loadBank(16'h0000, 3, 1'b0, -1, 1'b0);
    for (int i = 0; i < DEPTH0; i++) fetchQ0.push_back(DW'(i * 3));
    runFetch(0, 0, 0, 0, firstV, nValid, lastV, doneC, seen);
    checkOutput("nostall_first", firstV, 2);
    checkOutput("nostall_count", nValid, DEPTH0);
    checkOutput("nostall_lastcyc", lastV, 29);
    checkOutput("nostall_done", doneC, 30);
    checkOutput("nostall_drained", fetchQ0.size(), 0);

    $display("[TB] FETCH with stalls");
    for (int i = 0; i < DEPTH0; i++) fetchQ0.push_back(DW'(i * 3));
    runFetch(8, 4, 32, 1, firstV, nValid, lastV, doneC, seen);
    checkOutput("stall_count", nValid, DEPTH0);
    checkOutput("stall_v8", 32'(seen[8]), 1);
    for (int c = 9; c <= 12; c++) checkOutput("stall_gap1", 32'(seen[c]), 0);
    checkOutput("stall_v13", 32'(seen[13]), 1);
    checkOutput("stall_v32", 32'(seen[32]), 1);
    checkOutput("stall_gap2", 32'(seen[33]), 0);
    checkOutput("stall_lastcyc", lastV, 34);
    checkOutput("stall_done", doneC, 35);
    checkOutput("stall_drained", fetchQ0.size(), 0);

    $display("[TB] reset during FETCH");
    for (int i = 0; i < DEPTH0; i++) fetchQ0.push_back(DW'(i * 3));
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int c = 1; c <= 11; c++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("midrst_pre_en", 32'(if0.bram_en), 1);
    checkOutput("midrst_pre_addr", 32'(if0.bram_addr), 10);
    rst = 1'b1;
    #1;
    checkOutput("midrst_en", 32'(if0.bram_en), 0);
    checkOutput("midrst_valid", 32'(if0.w_valid), 0);
    checkOutput("midrst_busy", 32'(if0.busy), 0);
    checkOutput("midrst_done", 32'(if0.done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    fetchQ0.delete();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("midrst_no_done", 32'(if0.done), 0);
      checkOutput("midrst_idle", 32'(if0.busy), 0);
    end

    $display("[TB] start/load_req contention");
    loadBank(16'h0200, 1, 1'b0, 10, 1'b1);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("contention_no_fetch_busy", 32'(if0.busy), 0);
      checkOutput("contention_no_fetch_en", 32'(if0.bram_en), 0);
    end
    for (int i = 0; i < DEPTH0; i++) checkOutput("contention_readback", 32'(mem0[i]), 32'h0200 + i);

    $display("[TB] DEPTH=32 full-range FETCH");
    if1.load_req = 1'b1;
    tick();
    if1.load_req = 1'b0;
    for (int i = 0; i < DEPTH1; i++) begin
      if1.load_valid = 1'b1;
      if1.load_data  = DW'(32'hA000 + i);
      fetchQ1.push_back(DW'(32'hA000 + i));
      tick();
    end
    if1.load_valid = 1'b0;
    repeat (2) tick();
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    nValid = 0; lastV = -1; doneC = -1;
    for (int c = 1; c <= 50 && doneC < 0; c++) begin
      tick();
      if (if1.w_valid) begin
        nValid++;
        lastV = c;
      end
      if (if1.done) doneC = c;
    end
    checkOutput("d32_count", nValid, DEPTH1);
    checkOutput("d32_lastcyc", lastV, 33);
    checkOutput("d32_done", doneC, 34);
    checkOutput("d32_drained", fetchQ1.size(), 0);
    repeat (3) tick();
    checkOutput("d32_idle", 32'(if1.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
